mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage of the 5-stage RISC-V pipeline. Sits downstream of the EX/MEM pipeline register and feeds the MEM/WB register. Owns a word-wide, synchronous-read, single-port data RAM with no byte enables. Implements RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) with a small FSM: loads take 2 cycles, and sub-word stores use a 2-cycle read-modify-write. `busy` is the stall request that freezes PC, IF/ID, ID/EX and EX/MEM.

## Interface
- DATA_W, 32, data width in bits; fixed at 32.
- DM_ADDRESS, 9, byte-address width.
- MEM_WORDS, 128, RAM depth in words; equals 2^(DM_ADDRESS-2).

Ports (reset: synchronous, active-high; clock: clk):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request, from the EX/MEM register.
- MemWrite  in  1  store request, from the EX/MEM register.
- addr  in  DM_ADDRESS  byte address (ALU result bits [8:0]).
- wr_data  in  DATA_W  store data (forwarded rs2).
- func3  in  3  access size/sign, RV32I encoding.
- rd_data  out  DATA_W  load result, sign- or zero-extended.
- done  out  1  one-cycle pulse; the access completes this cycle.
- busy  out  1  combinational stall request.
- fault  out  1  misaligned access or illegal func3; no memory access is performed.

## Operation
- States: IDLE, LD_WAIT, ST_MERGE.
- RAM word index = addr[8:2]. Byte lane = addr[1:0].
- Request latch: in IDLE, an accepted multi-cycle request captures addr, func3 and wr_data into internal registers. LD_WAIT and ST_MERGE use only the latched values; inputs are ignored.
- Legal func3 values:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Anything else is illegal.
- Alignment rules:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
- MemRead and MemWrite both high: MemRead wins and the store is dropped.
- IDLE, legal aligned load:
  - Issue RAM read.
  - busy=1.
  - Next state LD_WAIT.
- LD_WAIT:
  - RAM output is valid.
  - rd_data = lane-selected, extended value: LB/LH sign-extend; LBU/LHU zero-extend.
  - done=1, busy=0.
  - Next state IDLE.
- IDLE, legal aligned SW:
  - Word written at the same edge.
  - done=1, busy=0.
  - Stay in IDLE.
- IDLE, legal aligned SB/SH:
  - Issue RAM read.
  - busy=1.
  - Next state ST_MERGE.
- ST_MERGE:
  - Merge the latched wr_data[7:0] (SB) or wr_data[15:0] (SH) into the selected lane(s) of the RAM output.
  - Write the merged word at the edge.
  - done=1, busy=0.
  - Next state IDLE.
- Illegal or misaligned request in IDLE:
  - fault=1, done=1, busy=0.
  - No RAM read or write; rd_data=0.
  - Stay in IDLE.
- No request (MemRead=MemWrite=0): outputs idle, rd_data=0.
- RAM contents are not cleared by reset. The full 512-byte space is mapped, so there is no out-of-range case.

## Timing
- Reset values: state IDLE, rd_data=0, done=0, busy=0, fault=0, latch registers=0.
- Load latency: request visible in cycle N; rd_data valid and done=1 in cycle N+1. MEM/WB captures rd_data at the end of cycle N+1.
- SW latency: 0 extra cycles; RAM updated at the end of cycle N.
- SB/SH latency: 1 stall cycle; RAM updated at the end of cycle N+1.
- busy is combinational from state, MemRead, MemWrite, func3 and addr. The pipeline holds EX/MEM while busy=1. busy is never high for 2 consecutive cycles for one request.
- Back-to-back requests: a new request may be presented in the cycle after done and is accepted from IDLE.
- Reset mid-operation: reset in LD_WAIT or ST_MERGE returns to IDLE with done=0. A pending ST_MERGE write is aborted and the RAM is unchanged.
- Same-word store then load: the load issued after the store edge must return the stored data (no bypass is needed, since the RAM write precedes the read).

## Test plan
- Word store/load: SW 0xDEADBEEF to addr 0x010, then LW 0x010 -> SW completes with no busy; LW gives busy=1 for 1 cycle, then rd_data=0xDEADBEEF with done=1.
- Byte store/signed loads: SB 0x80 to addr 0x013 over word 0x00000000 -> 1 stall cycle, word becomes 0x80000000. Then LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080.
- Halfword: SH 0x8001 to addr 0x022 -> word becomes 0x8001_xxxx with the low half preserved. LH 0x022 -> 0xFFFF8001; LHU -> 0x00008001.
- Faults: LW at 0x011, SH at 0x021, func3=3 load -> fault=1, busy=0, rd_data=0, RAM unchanged.
- Reset mid-RMW: SB 0x55 to 0x030, assert reset in the ST_MERGE cycle -> state IDLE, word at 0x030 unchanged, outputs 0.
- Simultaneous MemRead and MemWrite at 0x040 holding 0x12345678, func3=2 -> load performed, rd_data=0x12345678, RAM unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage of the 5-stage RV32I pipeline.
// Owns a word-wide, synchronous-read, single-port data RAM without byte
// enables. Loads take two cycles; SW completes in the request cycle;
// SB/SH run a two-cycle read-modify-write.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   MemRead   load request from EX/MEM
//   MemWrite  store request from EX/MEM (ignored when MemRead is also high)
//   addr      byte address
//   wr_data   store data
//   func3     RV32I access size/sign
//   rd_data   load result, sign/zero-extended; 0 when not completing a load
//   done      access completes this cycle
//   busy      combinational stall request for PC, IF/ID, ID/EX, EX/MEM
//   fault     misaligned access or illegal func3; no RAM access performed
module mem_access_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  done,
    output logic                  busy,
    output logic                  fault
);

    localparam int unsigned IDX_W     = DM_ADDRESS - 2;
    localparam int unsigned MEM_WORDS = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        ST_MERGE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [2:0]            func3_q, func3_d;
    logic [15:0]           wdata_q, wdata_d;   // only the sub-word part is ever merged

    logic [DATA_W-1:0]     mem [MEM_WORDS];
    logic [DATA_W-1:0]     ram_q;
    logic                  ram_re;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     merge_word;

    logic                  ld_legal;
    logic                  st_legal;
    logic                  aligned;

    // Lane-select the RAM word and extend according to func3.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [2:0]        f3);
        logic [DATA_W-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'd0:    load_ext = {{(DATA_W-8){sh[7]}}, sh[7:0]};
            3'd1:    load_ext = {{(DATA_W-16){sh[15]}}, sh[15:0]};
            3'd4:    load_ext = {{(DATA_W-8){1'b0}}, sh[7:0]};
            3'd5:    load_ext = {{(DATA_W-16){1'b0}}, sh[15:0]};
            default: load_ext = word;
        endcase
    endfunction

    // Request decode on the live inputs (only meaningful in IDLE).
    always_comb begin
        ld_legal = func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_legal = func3 inside {3'd0, 3'd1, 3'd2};
        case (func3[1:0])
            2'd1:    aligned = (addr[0] == 1'b0);
            2'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Merge the latched store data into the word read back from RAM.
    always_comb begin
        merge_word = ram_q;
        if (func3_q[0]) begin
            merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Next-state, RAM control and outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        func3_d   = func3_q;
        wdata_d   = wdata_q;
        rd_data   = '0;
        done      = 1'b0;
        busy      = 1'b0;
        fault     = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = addr[DM_ADDRESS-1:2];
        ram_wdata = wr_data;

        case (state_q)
            IDLE: begin
                if (MemRead) begin
                    if (ld_legal && aligned) begin
                        ram_re  = 1'b1;
                        busy    = 1'b1;
                        addr_d  = addr;
                        func3_d = func3;
                        wdata_d = wr_data[15:0];
                        state_d = LD_WAIT;
                    end else begin
                        fault = 1'b1;
                        done  = 1'b1;
                    end
                end else if (MemWrite) begin
                    if (st_legal && aligned) begin
                        if (func3 == 3'd2) begin
                            ram_we = 1'b1;
                            done   = 1'b1;
                        end else begin
                            ram_re  = 1'b1;
                            busy    = 1'b1;
                            addr_d  = addr;
                            func3_d = func3;
                            wdata_d = wr_data[15:0];
                            state_d = ST_MERGE;
                        end
                    end else begin
                        fault = 1'b1;
                        done  = 1'b1;
                    end
                end
            end
            LD_WAIT: begin
                rd_data = load_ext(ram_q, addr_q[1:0], func3_q);
                done    = 1'b1;
                state_d = IDLE;
            end
            ST_MERGE: begin
                ram_idx   = addr_q[DM_ADDRESS-1:2];
                ram_wdata = merge_word;
                ram_we    = 1'b1;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts any in-flight access, including a pending RMW write.
        if (reset) begin
            rd_data = '0;
            done    = 1'b0;
            busy    = 1'b0;
            fault   = 1'b0;
            ram_re  = 1'b0;
            ram_we  = 1'b0;
        end
    end

    // State and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
        end
    end

    // Single-port synchronous RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
        if (ram_re) begin
            ram_q <= mem[ram_idx];
        end
    end

endmodule
